// File: rtl/snitch_load_rob.sv
// snitch_load_rob: hands out load IDs in order, collects out-of-order responses, releases in issue order
module snitch_load_rob #(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned NumOutstanding = 8,
  parameter int unsigned IdWidth        = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1,
  parameter int unsigned CntWidth       = $clog2(NumOutstanding + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 alloc_valid_i,
  output logic                 alloc_ready_o,
  output logic [IdWidth-1:0]   alloc_id_o,
  input  logic                 resp_valid_i,
  input  logic [IdWidth-1:0]   resp_id_i,
  input  logic [DataWidth-1:0] resp_data_i,
  input  logic                 resp_error_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [IdWidth-1:0]   out_id_o,
  output logic [DataWidth-1:0] out_data_o,
  output logic                 out_error_o,
  output logic [CntWidth-1:0]  count_o,
  output logic                 empty_o,
  output logic                 proto_err_o
);
  localparam logic [IdWidth-1:0]  LAST = IdWidth'(NumOutstanding - 1);
  localparam logic [CntWidth-1:0] FULL = CntWidth'(NumOutstanding);
  localparam logic [IdWidth:0]    NUM  = (IdWidth + 1)'(NumOutstanding);
  logic [IdWidth-1:0]        head_q, tail_q;
  logic [CntWidth-1:0]       count_q;
  logic [NumOutstanding-1:0] alloc_q, filled_q, err_q;
  logic [DataWidth-1:0]      data_q [NumOutstanding];
  logic                      proto_err_q;
  logic                      do_alloc, do_release, resp_ok;
  // alloc_ready looks only at registered count, so a release never frees a slot in the same cycle
  assign alloc_ready_o = count_q != FULL;
  assign alloc_id_o    = tail_q;
  assign do_alloc      = alloc_valid_i && alloc_ready_o;
  assign out_valid_o   = alloc_q[head_q] && filled_q[head_q];
  assign do_release    = out_valid_o && out_ready_i;
  assign out_id_o      = head_q;
  assign out_data_o    = data_q[head_q];
  assign out_error_o   = err_q[head_q];
  assign count_o       = count_q;
  assign empty_o       = count_q == '0;
  assign proto_err_o   = proto_err_q;
  assign resp_ok       = resp_valid_i && ({1'b0, resp_id_i} < NUM) &&
                         alloc_q[resp_id_i] && !filled_q[resp_id_i];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      alloc_q     <= '0;
      filled_q    <= '0;
      err_q       <= '0;
      proto_err_q <= 1'b0;
      for (int i = 0; i < NumOutstanding; i++) data_q[i] <= '0;
    end else begin
      if (do_alloc) begin
        alloc_q[tail_q]  <= 1'b1;
        filled_q[tail_q] <= 1'b0;
        tail_q           <= (tail_q == LAST) ? '0 : tail_q + 1'b1;
      end
      if (resp_ok) begin
        data_q[resp_id_i]   <= resp_data_i;
        err_q[resp_id_i]    <= resp_error_i;
        filled_q[resp_id_i] <= 1'b1;
      end
      if (do_release) begin
        alloc_q[head_q]  <= 1'b0;
        filled_q[head_q] <= 1'b0;
        head_q           <= (head_q == LAST) ? '0 : head_q + 1'b1;
      end
      count_q     <= count_q + CntWidth'(do_alloc) - CntWidth'(do_release);
      proto_err_q <= resp_valid_i && !resp_ok;
    end
  end
endmodule

// File: tb/tb_snitch_load_rob.sv
// tb_snitch_load_rob: directed and random checks of the load ROB against a queue-based reference
module tb_snitch_load_rob;
  localparam int N = 5;
  localparam int IW = 3;
  localparam int CW = 3;
  typedef struct {
    int          id;
    bit          f;
    logic [31:0] d;
    bit          e;
  } ent_t;
  logic clk = 0, rst = 1;
  logic alloc_valid = 0, resp_valid = 0, resp_error = 0, out_ready = 0;
  logic [IW-1:0] resp_id = '0;
  logic [31:0] resp_data = '0;
  logic alloc_ready, out_valid, out_error, empty, proto_err;
  logic [IW-1:0] alloc_id, out_id;
  logic [31:0] out_data;
  logic [CW-1:0] count;
  int n_cmp = 0, n_err = 0;
  ent_t q[$];
  int m_next = 0;
  bit m_perr = 0;
  logic [32:0] rel_log[$];

  snitch_load_rob #(.DataWidth(32), .NumOutstanding(N)) dut (
    .clk_i(clk), .rst_i(rst),
    .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready), .alloc_id_o(alloc_id),
    .resp_valid_i(resp_valid), .resp_id_i(resp_id), .resp_data_i(resp_data), .resp_error_i(resp_error),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_id_o(out_id),
    .out_data_o(out_data), .out_error_o(out_error),
    .count_o(count), .empty_o(empty), .proto_err_o(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    bit ev, rel, al, legal;
    @(negedge clk);
    ev = q.size() > 0 && q[0].f;
    check("alloc_ready", alloc_ready, q.size() != N);
    check("alloc_id", alloc_id, m_next);
    check("out_valid", out_valid, ev);
    check("out_id", out_id, q.size() > 0 ? q[0].id : m_next);
    check("count", count, q.size());
    check("empty", empty, q.size() == 0);
    check("proto_err", proto_err, m_perr);
    if (ev) begin
      check("out_data", out_data, q[0].d);
      check("out_error", out_error, q[0].e);
    end
    if (out_valid && out_ready) rel_log.push_back({out_error, out_data});
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_next = 0;
      m_perr = 0;
    end else begin
      rel = ev && out_ready;
      al = alloc_valid && q.size() != N;
      legal = 0;
      if (resp_valid)
        foreach (q[k])
          if (q[k].id == int'(resp_id) && !q[k].f) begin
            q[k].f = 1;
            q[k].d = resp_data;
            q[k].e = resp_error;
            legal = 1;
          end
      m_perr = resp_valid && !legal;
      if (rel) void'(q.pop_front());
      if (al) begin
        q.push_back('{m_next, 0, 32'h0, 0});
        m_next = (m_next + 1) % N;
      end
    end
    #1;
  endtask

  task automatic respond(input int id, input logic [31:0] d, input bit e);
    resp_valid = 1;
    resp_id = IW'(id);
    resp_data = d;
    resp_error = e;
    cyc();
    resp_valid = 0;
    resp_error = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    alloc_valid = 0;
    resp_valid = 0;
    out_ready = 0;
    cyc();
    rst = 0;
    rel_log.delete();
  endtask

  task automatic check_log(input string tag, input int idx, input logic [32:0] exp);
    check(tag, rel_log.size() > idx ? rel_log[idx] : 33'h1_dead_beef, exp);
  endtask

  initial begin
    int cand[$];
    #1;
    // reset values
    do_reset();
    cyc();
    check("reset_data", out_data, 0);
    check("reset_err", out_error, 0);
    // in-order flow
    alloc_valid = 1;
    repeat (3) cyc();
    alloc_valid = 0;
    out_ready = 1;
    respond(0, 32'hA0, 0);
    respond(1, 32'hA1, 0);
    respond(2, 32'hA2, 0);
    cyc();
    cyc();
    check("inorder_n", rel_log.size(), 3);
    check_log("inorder0", 0, 33'hA0);
    check_log("inorder1", 1, 33'hA1);
    check_log("inorder2", 2, 33'hA2);
    check("inorder_cnt", count, 0);
    // out-of-order return
    do_reset();
    alloc_valid = 1;
    repeat (4) cyc();
    alloc_valid = 0;
    out_ready = 1;
    respond(3, 32'h30, 0);
    respond(1, 32'h10, 0);
    respond(2, 32'h20, 0);
    check("ooo_blocked", out_valid, 0);
    respond(0, 32'h00, 0);
    repeat (5) cyc();
    check("ooo_n", rel_log.size(), 4);
    check_log("ooo0", 0, 33'h00);
    check_log("ooo1", 1, 33'h10);
    check_log("ooo2", 2, 33'h20);
    check_log("ooo3", 3, 33'h30);
    // full, wrap and error flag
    do_reset();
    alloc_valid = 1;
    repeat (5) cyc();
    check("full_ready", alloc_ready, 0);
    out_ready = 1;
    respond(0, 32'h55, 1);
    cyc();
    check("wrap_id", alloc_id, 0);
    check("wrap_ready", alloc_ready, 1);
    cyc();
    alloc_valid = 0;
    check("wrap_cnt", count, 5);
    check_log("err_flag", 0, {1'b1, 32'h55});
    for (int i = 1; i < 5; i++) respond(i, 32'h60 + i, 0);
    respond(0, 32'h70, 0);
    repeat (2) cyc();
    check_log("wrap_rel", 5, 33'h70);
    // illegal responses
    do_reset();
    alloc_valid = 1;
    repeat (3) cyc();
    alloc_valid = 0;
    respond(2, 32'h22, 0);
    respond(6, 32'h66, 0);
    check("ill_unalloc", proto_err, 1);
    respond(2, 32'h99, 0);
    check("ill_dup", proto_err, 1);
    cyc();
    check("ill_pulse", proto_err, 0);
    respond(0, 32'h1, 0);
    respond(1, 32'h2, 0);
    out_ready = 1;
    repeat (4) cyc();
    check_log("dup_kept", 2, 33'h22);
    // reset mid-operation
    do_reset();
    alloc_valid = 1;
    repeat (4) cyc();
    alloc_valid = 0;
    respond(0, 32'hC0, 0);
    respond(2, 32'hC2, 0);
    rst = 1;
    cyc();
    rst = 0;
    check("mid_data", out_data, 0);
    respond(1, 32'hC1, 0);
    check("late_perr", proto_err, 1);
    out_ready = 1;
    repeat (3) cyc();
    check("late_norel", rel_log.size(), 0);
    // random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      alloc_valid = $urandom_range(0, 2) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      cand.delete();
      foreach (q[k]) if (!q[k].f) cand.push_back(q[k].id);
      resp_valid = $urandom_range(0, 1);
      resp_id = (cand.size() > 0 && $urandom_range(0, 9) != 0)
                ? IW'(cand[$urandom_range(0, cand.size() - 1)]) : IW'($urandom_range(0, 7));
      resp_data = $urandom;
      resp_error = $urandom_range(0, 7) == 0;
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
